// File: rtl/led_display_pkg.sv
// Shared types and constants for the signed-value 7-segment display stage:
// FSM states, active-low segment codes (gfedcba) and BCD width.
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_e;

    localparam int BCD_W = 12;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_MINUS = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/led_display_if.sv
// Value in, four active-low digits and a busy flag out. The display is the
// slave; whoever drives Value (core or bench) is the master.
interface led_display_if;
    logic [7:0] Value;
    logic [6:0] HEX3;
    logic [6:0] HEX2;
    logic [6:0] HEX1;
    logic [6:0] HEX0;
    logic       Busy;

    modport slave  (input Value, output HEX3, output HEX2, output HEX1, output HEX0, output Busy);
    modport master (output Value, input HEX3, input HEX2, input HEX1, input HEX0, input Busy);
endinterface

// File: rtl/led_display_bcd_to_seg7.sv
// Combinational BCD digit to active-low 7-segment code with blank override.
// Codes above 9 never arise from the converter and decode to blank.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] bcd_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (!blank_i) begin
            case (bcd_i)
                4'd0:    seg_o = SEG_0;
                4'd1:    seg_o = SEG_1;
                4'd2:    seg_o = SEG_2;
                4'd3:    seg_o = SEG_3;
                4'd4:    seg_o = SEG_4;
                4'd5:    seg_o = SEG_5;
                4'd6:    seg_o = SEG_6;
                4'd7:    seg_o = SEG_7;
                4'd8:    seg_o = SEG_8;
                4'd9:    seg_o = SEG_9;
                default: seg_o = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/led_display.sv
// Signed 8-bit value to sign/hundreds/tens/units display via a sequential
// double-dabble engine; the four digits update together when a conversion ends.
module led_display
    import seg7_pkg::*;
#(
    parameter bit BLANK_ZEROS = 1'b1
) (
    input  logic          Clock,
    input  logic          nReset,
    led_display_if.slave  bus
);

    localparam logic [6:0] HEX_LEAD_RST = BLANK_ZEROS ? SEG_BLANK : SEG_0;

    state_e             state_q, state_d;
    logic [7:0]         val_q;
    logic [7:0]         snap_q, snap_d;
    logic [7:0]         bin_q, bin_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               neg_q, neg_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [6:0]         hex3_q, hex3_d;
    logic [6:0]         hex2_q, hex2_d;
    logic [6:0]         hex1_q, hex1_d;
    logic [6:0]         hex0_q, hex0_d;

    logic [BCD_W-1:0]   bcd_adj;
    logic [2:0]         blank_en;
    logic [6:0]         seg_w [3];

    // Blank leading zeros only: tens blanks when hundreds is also zero.
    assign blank_en[2] = BLANK_ZEROS && (bcd_q[11:8] == 4'd0);
    assign blank_en[1] = blank_en[2] && (bcd_q[7:4] == 4'd0);
    assign blank_en[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_digit
            assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ? bcd_q[4*gi +: 4] + 4'd3
                                                                   : bcd_q[4*gi +: 4];
            bcd_to_seg7 u_dec (
                .bcd_i   (bcd_q[4*gi +: 4]),
                .blank_i (blank_en[gi]),
                .seg_o   (seg_w[gi])
            );
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        neg_d   = neg_q;
        cnt_d   = cnt_q;
        hex3_d  = hex3_q;
        hex2_d  = hex2_q;
        hex1_d  = hex1_q;
        hex0_d  = hex0_q;
        case (state_q)
            IDLE: begin
                if (val_q != snap_q) begin
                    snap_d  = val_q;
                    // Two's-complement magnitude; -128 wraps to 8'h80 = 128.
                    bin_d   = val_q[7] ? (~val_q + 8'd1) : val_q;
                    neg_d   = val_q[7];
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = CONV;
                end
            end
            CONV: begin
                {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) state_d = DONE;
            end
            DONE: begin
                hex3_d  = neg_q ? SEG_MINUS : SEG_BLANK;
                hex2_d  = seg_w[2];
                hex1_d  = seg_w[1];
                hex0_d  = seg_w[0];
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q <= IDLE;
            val_q   <= '0;
            snap_q  <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
            hex3_q  <= SEG_BLANK;
            hex2_q  <= HEX_LEAD_RST;
            hex1_q  <= HEX_LEAD_RST;
            hex0_q  <= SEG_0;
        end else begin
            state_q <= state_d;
            val_q   <= bus.Value;
            snap_q  <= snap_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            neg_q   <= neg_d;
            cnt_q   <= cnt_d;
            hex3_q  <= hex3_d;
            hex2_q  <= hex2_d;
            hex1_q  <= hex1_d;
            hex0_q  <= hex0_d;
        end
    end

    assign bus.HEX3 = hex3_q;
    assign bus.HEX2 = hex2_q;
    assign bus.HEX1 = hex1_q;
    assign bus.HEX0 = hex0_q;
    assign bus.Busy = (state_q != IDLE);

endmodule

// File: tb/tb_led_display.sv
// Directed bench for led_display: two instances (leading-zero blanking on and
// off) share clock, reset and stimulus; a division-based model covers the sweep.
module tb_led_display;

    logic clk = 1'b0;
    logic nReset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    led_display_if ifa ();
    led_display_if ifb ();

    led_display #(.BLANK_ZEROS(1'b1)) dut_a (.Clock(clk), .nReset(nReset), .bus(ifa.slave));
    led_display #(.BLANK_ZEROS(1'b0)) dut_b (.Clock(clk), .nReset(nReset), .bus(ifb.slave));

    always #5 clk = ~clk;

    wire [27:0] hex_a = {ifa.HEX3, ifa.HEX2, ifa.HEX1, ifa.HEX0};
    wire [27:0] hex_b = {ifb.HEX3, ifb.HEX2, ifb.HEX1, ifb.HEX0};

    localparam logic [27:0] RST_A = {7'h7F, 7'h7F, 7'h7F, 7'h40};
    localparam logic [27:0] RST_B = {7'h7F, 7'h40, 7'h40, 7'h40};

    task automatic chk(input string tag, input logic [27:0] obs, input logic [27:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        logic [6:0] tbl [10];
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        return tbl[d];
    endfunction

    function automatic logic [27:0] ref_hex(input logic [7:0] v, input bit blank);
        int mag, h, t, u;
        logic [6:0] s3, s2, s1, s0;
        mag = v[7] ? 256 - int'(v) : int'(v);
        h = mag / 100;
        t = (mag / 10) % 10;
        u = mag % 10;
        s3 = v[7] ? 7'h3F : 7'h7F;
        s2 = (blank && h == 0) ? 7'h7F : seg_of(h);
        s1 = (blank && h == 0 && t == 0) ? 7'h7F : seg_of(t);
        s0 = seg_of(u);
        return {s3, s2, s1, s0};
    endfunction

    // Called just after a sampling negedge; applies v and follows 14 cycles.
    task automatic conv(input logic [7:0] v, input logic [27:0] ea, input logic [27:0] eb,
                        input string tag);
        logic [27:0] pa, pb;
        int busy_a, busy_b, first_a, first_b;
        pa = hex_a; pb = hex_b;
        busy_a = 0; busy_b = 0; first_a = 0; first_b = 0;
        ifa.Value = v;
        ifb.Value = v;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            if (ifa.Busy) busy_a++;
            if (ifb.Busy) busy_b++;
            if (first_a == 0 && hex_a !== pa) first_a = n;
            if (first_b == 0 && hex_b !== pb) first_b = n;
            if (hex_a !== pa && hex_a !== ea) chk({tag, "_glitchA"}, hex_a, ea);
            if (hex_b !== pb && hex_b !== eb) chk({tag, "_glitchB"}, hex_b, eb);
        end
        chk({tag, "_hexA"}, hex_a, ea);
        chk({tag, "_hexB"}, hex_b, eb);
        chk({tag, "_busyA"}, 28'(busy_a), 28'd9);
        chk({tag, "_busyB"}, 28'(busy_b), 28'd9);
        if (pa !== ea) chk({tag, "_latA"}, 28'(first_a), 28'd11);
        if (pb !== eb) chk({tag, "_latB"}, 28'(first_b), 28'd11);
        $display("conv %s value=%0d hexA=%h hexB=%h", tag, $signed(v), hex_a, hex_b);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [27:0] e127a, e40a, e40b, prev_a;
        int busy_a;
        ifa.Value = 8'd0;
        ifb.Value = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_hexA", hex_a, RST_A);
        chk("rst_hexB", hex_b, RST_B);
        nReset = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            chk("idle_hexA", hex_a, RST_A);
            chk("idle_busyA", 28'(ifa.Busy), 28'd0);
            chk("idle_busyB", 28'(ifb.Busy), 28'd0);
        end
        $display("reset/idle hold: hexA=%h hexB=%h", hex_a, hex_b);

        conv(8'd123, {7'h7F, 7'h79, 7'h24, 7'h30}, {7'h7F, 7'h79, 7'h24, 7'h30}, "p123");
        conv(8'h80,  {7'h3F, 7'h79, 7'h24, 7'h00}, {7'h3F, 7'h79, 7'h24, 7'h00}, "m128");
        conv(8'hFB,  {7'h3F, 7'h7F, 7'h7F, 7'h12}, {7'h3F, 7'h40, 7'h40, 7'h12}, "m5");

        // 127 then 40 arriving mid-conversion: 127 first, then 40, back-to-back.
        e127a = {7'h7F, 7'h79, 7'h24, 7'h78};
        e40a  = {7'h7F, 7'h7F, 7'h19, 7'h40};
        e40b  = {7'h7F, 7'h40, 7'h19, 7'h40};
        prev_a = hex_a;
        busy_a = 0;
        ifa.Value = 8'd127;
        ifb.Value = 8'd127;
        for (int n = 1; n <= 22; n++) begin
            @(negedge clk);
            if (ifa.Busy) busy_a++;
            if (hex_a !== prev_a && hex_a !== e127a && hex_a !== e40a)
                chk("chg_glitchA", hex_a, e40a);
            if (n == 10) chk("chg_before127", hex_a, prev_a);
            if (n == 11) chk("chg_127A", hex_a, e127a);
            if (n == 11) chk("chg_127B", hex_b, e127a);
            if (n == 20) chk("chg_hold127", hex_a, e127a);
            if (n == 21) chk("chg_40A", hex_a, e40a);
            if (n == 21) chk("chg_40B", hex_b, e40b);
            if (n == 11) chk("chg_idle_gap", 28'(ifa.Busy), 28'd0);
            if (n == 6) begin
                ifa.Value = 8'd40;
                ifb.Value = 8'd40;
            end
        end
        chk("chg_busyA", 28'(busy_a), 28'd18);
        $display("change 127->40: hexA=%h hexB=%h", hex_a, hex_b);

        // Reset in the middle of converting 99, then reconvert after release.
        ifa.Value = 8'd99;
        ifb.Value = 8'd99;
        repeat (5) @(negedge clk);
        chk("mid_busy", 28'(ifa.Busy), 28'd1);
        nReset = 1'b0;
        #1;
        chk("mid_rst_hexA", hex_a, RST_A);
        chk("mid_rst_hexB", hex_b, RST_B);
        chk("mid_rst_busy", 28'(ifa.Busy), 28'd0);
        repeat (2) @(negedge clk);
        nReset = 1'b1;
        conv(8'd99, {7'h7F, 7'h7F, 7'h10, 7'h10}, {7'h7F, 7'h40, 7'h10, 7'h10}, "p99");

        // Sweep every value once in a scrambled order (37 is odd, so a permutation).
        for (int i = 0; i < 256; i++) begin
            logic [7:0] v;
            v = 8'(i * 37 + 11);
            conv(v, ref_hex(v, 1'b1), ref_hex(v, 1'b0), "sweep");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
